// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, boot address, fetch FSM states,
// major opcodes and a word-alignment helper.
package rv32i_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetchState_t;

    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and decode handshake bundle of the fetch stage.
// The master modport is the fetch unit, the slave modport is its environment.
interface fetch_unit_if;
    import rv32i_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [6:0]      id_opcode;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_opcode, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_target, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_opcode, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_target, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry decode buffer holding {pc, instr}; the head entry is read straight
// from registers so decode sees data one cycle after the push.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [2*XLEN-1:0] i_data,
    output logic [2*XLEN-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [2*XLEN-1:0] r_mem [2];
    logic              r_rdPtr;
    logic              r_wrPtr;
    logic [1:0]        r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign w_doPop  = i_pop && (r_count != 2'd0);
    assign w_doPush = i_push && ((r_count != 2'(DEPTH)) || w_doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: at most two words in flight or buffered, with
// redirect handling that drops responses to requests issued before the branch.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetchState_t       r_state;
    fetchState_t       w_stateNext;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_tagPc;
    logic [XLEN-1:0]   w_pcNext;
    logic [XLEN-1:0]   w_tagPcNext;
    logic [1:0]        r_outstanding;
    logic [1:0]        r_stale;
    logic [1:0]        w_outNext;
    logic [1:0]        w_staleNext;
    logic [1:0]        w_cntNext;
    logic [1:0]        w_fifoCount;
    logic              r_reqValid;
    logic              w_reqValidNext;
    logic              w_reqFire;
    logic              w_rspAccept;
    logic              w_rspKeep;
    logic              w_redirect;
    logic              w_pop;
    logic              w_idValid;
    logic [2*XLEN-1:0] w_fifoHead;

    assign w_redirect  = bus.redirect_valid && (r_state != BOOT);
    assign w_reqFire   = r_reqValid && bus.imem_req_ready;
    assign w_rspAccept = bus.imem_rsp_valid && (r_outstanding != 2'd0);
    assign w_rspKeep   = w_rspAccept && (r_stale == 2'd0) && !w_redirect;
    assign w_idValid   = (w_fifoCount != 2'd0);
    assign w_pop       = w_idValid && bus.id_ready;
    assign w_outNext   = r_outstanding + {1'b0, w_reqFire} - {1'b0, w_rspAccept};
    assign w_cntNext   = w_redirect ? 2'd0 : (w_fifoCount + {1'b0, w_rspKeep} - {1'b0, w_pop});

    // r_tagPc tracks the address of the next non-stale response; requests are
    // sequential since the last redirect, so it only ever steps by one word.
    always_comb begin
        w_stateNext = r_state;
        w_staleNext = r_stale;
        w_pcNext    = r_pc;
        w_tagPcNext = r_tagPc;
        case (r_state)
            BOOT:    w_stateNext = FETCH;
            FETCH:   if (w_redirect) w_stateNext = FLUSH;
            FLUSH:   if (!w_redirect && (r_stale == 2'd0)) w_stateNext = FETCH;
            default: w_stateNext = BOOT;
        endcase
        if (w_redirect && (r_state == FETCH)) begin
            w_staleNext = w_outNext;
        end else if (w_rspAccept && (r_stale != 2'd0)) begin
            w_staleNext = r_stale - 2'd1;
        end
        if (w_redirect) begin
            w_pcNext    = wordAlign(bus.redirect_target);
            w_tagPcNext = wordAlign(bus.redirect_target);
        end else begin
            if (w_reqFire) w_pcNext = r_pc + 32'd4;
            if (w_rspKeep) w_tagPcNext = r_tagPc + 32'd4;
        end
        w_reqValidNext = (w_stateNext == FETCH) &&
                         (({1'b0, w_outNext} + {1'b0, w_cntNext}) < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_tagPc       <= RESET_PC;
            r_outstanding <= 2'd0;
            r_stale       <= 2'd0;
            r_reqValid    <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_pc          <= w_pcNext;
            r_tagPc       <= w_tagPcNext;
            r_outstanding <= w_outNext;
            r_stale       <= w_staleNext;
            r_reqValid    <= w_reqValidNext;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rspKeep),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_data  ({r_tagPc, bus.imem_rsp_data}),
        .o_head  (w_fifoHead),
        .o_count (w_fifoCount)
    );

    assign bus.imem_req_valid = r_reqValid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.id_valid       = w_idValid;
    assign bus.id_pc          = w_fifoHead[2*XLEN-1:XLEN];
    assign bus.id_instr       = w_fifoHead[XLEN-1:0];
    assign bus.id_opcode      = w_fifoHead[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed startup/stall/redirect/wrap cases
// followed by randomized traffic against a program-order reference model.
module tb_fetch_unit;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    memReq_t     memQ[$];
    int          checks = 0;
    int          errors = 0;
    int          stepNo = 0;
    int          stepsSinceReset = 0;
    int          lastDue = 0;
    int          reqCount = 0;
    int          popCount = 0;
    int          latMin = 1;
    int          latMax = 1;
    logic [31:0] expReqPc;
    logic [31:0] expIdPc;
    logic [31:0] lastReqAddr;
    logic [31:0] lastPopPc;

    // Memory contents are a fixed hash of the address.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0013};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Called at a falling edge: samples outputs, updates the model for the
    // handshakes of the coming rising edge, drives inputs, advances one cycle.
    task automatic applyStimulus(input bit reqReady, input bit idReady, input bit redir,
                                 input logic [31:0] target);
        logic        rspV;
        logic [31:0] rspD;
        logic [31:0] expInstr;
        memReq_t     r;
        int          lat;
        rspV = 1'b0;
        rspD = '0;
        if (memQ.size() > 0 && memQ[0].due <= stepNo) begin
            rspV = 1'b1;
            rspD = memData(memQ[0].addr);
            void'(memQ.pop_front());
        end
        if (bus.imem_req_valid) begin
            checkOutput("reqAddr", bus.imem_req_addr, expReqPc);
            if (reqReady) begin
                lastReqAddr = bus.imem_req_addr;
                reqCount++;
                lat = $urandom_range(latMax, latMin);
                r.addr = bus.imem_req_addr;
                r.due = stepNo + lat;
                if (r.due <= lastDue) r.due = lastDue + 1;
                lastDue = r.due;
                memQ.push_back(r);
                checkOutput("inflightLimit", 32'(memQ.size() <= 2), 32'd1);
                expReqPc = expReqPc + 32'd4;
            end
        end
        if (bus.id_valid) begin
            expInstr = memData(expIdPc);
            checkOutput("idPc", bus.id_pc, expIdPc);
            checkOutput("idInstr", bus.id_instr, expInstr);
            checkOutput("idOpcode", 32'(bus.id_opcode), 32'(expInstr[6:0]));
            if (idReady) begin
                lastPopPc = bus.id_pc;
                popCount++;
                expIdPc = expIdPc + 32'd4;
            end
        end
        if (redir) begin
            expReqPc = {target[31:2], 2'b00};
            expIdPc  = {target[31:2], 2'b00};
        end
        bus.imem_req_ready  = reqReady;
        bus.id_ready        = idReady;
        bus.redirect_valid  = redir;
        bus.redirect_target = target;
        bus.imem_rsp_valid  = rspV;
        bus.imem_rsp_data   = rspD;
        @(posedge clk);
        @(negedge clk);
        stepNo++;
        stepsSinceReset++;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.id_ready        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        memQ.delete();
        lastDue = stepNo;
        repeat (2) @(negedge clk);
        checkOutput("rstReqValid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("rstIdValid", 32'(bus.id_valid), 32'd0);
        checkOutput("rstReqAddr", bus.imem_req_addr, 32'h0000_0000);
        checkOutput("rstIdPc", bus.id_pc, 32'd0);
        checkOutput("rstIdInstr", bus.id_instr, 32'd0);
        rst_n = 1'b1;
        expReqPc = 32'h0000_0000;
        expIdPc  = 32'h0000_0000;
        stepsSinceReset = 0;
        reqCount = 0;
        popCount = 0;
    endtask

    initial begin
        int foundAt;
        int base;
        bit found;
        rst_n = 1'b0;
        @(negedge clk);

        $display("[TB] startup latency with 1-cycle memory");
        latMin = 1; latMax = 1;
        doReset();
        foundAt = -1;
        for (int i = 0; i < 10 && foundAt < 0; i++) begin
            if (bus.id_valid) begin
                foundAt = i;
                checkOutput("firstIdPc", bus.id_pc, 32'h0);
            end else begin
                applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            end
        end
        checkOutput("firstIdLatency", 32'(foundAt), 32'd3);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("startupReqs", 32'(reqCount >= 3), 32'd1);

        $display("[TB] decode stalled");
        doReset();
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stallReqCount", 32'(reqCount), 32'd2);
        checkOutput("stallReqValid", 32'(bus.imem_req_valid), 32'd0);
        base = reqCount;
        for (int i = 0; i < 10 && reqCount == base; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("resumeReqSeen", 32'(reqCount > base), 32'd1);
        checkOutput("resumeReqAddr", lastReqAddr, 32'h0000_0008);

        $display("[TB] redirect with two outstanding");
        doReset();
        latMin = 4; latMax = 4;
        for (int i = 0; i < 10 && memQ.size() != 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("twoOutstanding", 32'(memQ.size()), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        checkOutput("flushReqValid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("flushIdValid", 32'(bus.id_valid), 32'd0);
        base = popCount;
        for (int i = 0; i < 40 && popCount == base; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redirPopSeen", 32'(popCount > base), 32'd1);
        checkOutput("redirFirstPc", lastPopPc, 32'h0000_0100);

        $display("[TB] unaligned redirect target");
        latMin = 1; latMax = 3;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        base = reqCount;
        for (int i = 0; i < 30 && reqCount == base; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("alignReqAddr", lastReqAddr, 32'h0000_0200);

        $display("[TB] redirect coinciding with handshake");
        doReset();
        latMin = 1; latMax = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.id_valid && bus.id_pc == 32'h8) found = 1'b1;
            else applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("reachedPc8", 32'(found), 32'd1);
        base = popCount;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        checkOutput("pc8PoppedOnce", 32'(popCount - base), 32'd1);
        checkOutput("pc8PopPc", lastPopPc, 32'h0000_0008);
        base = popCount;
        for (int i = 0; i < 30 && popCount == base; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("afterPc8Pc", lastPopPc, 32'h0000_0300);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        base = reqCount;
        for (int i = 0; i < 30 && reqCount < base + 1; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrapReq0", lastReqAddr, 32'hFFFF_FFFC);
        for (int i = 0; i < 30 && reqCount < base + 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("wrapReq1", lastReqAddr, 32'h0000_0000);

        $display("[TB] randomized traffic with mid-run resets");
        latMin = 1; latMax = 4;
        for (int round = 0; round < 2; round++) begin
            doReset();
            for (int i = 0; i < 1500; i++) begin
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                              (stepsSinceReset > 2) && ($urandom_range(0, 29) == 0),
                              $urandom);
            end
            checkOutput("randomProgress", 32'(popCount > 50), 32'd1);
        end
        doReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
